hcsr04_controller: RTL and testbench
====================================

HCSR04_CONTROLLER -- requirements
Module: hcsr04_controller

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 12: trigger pulse width in clock cycles (1 cycle = 1 us at 1 MHz).
REQ-002 SHALL have parameter US_PER_CM, default 58: echo cycles per centimetre.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 30000: maximum wait for echo rise, and maximum echo-high duration.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 200: idle gap enforced after every measurement.
REQ-005 SHALL have port clock  in  1  system clock; one clock, rising edge only.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port medir  in  1  measurement request, level-sampled.
REQ-008 SHALL have port echo  in  1  sensor echo, asynchronous.
REQ-009 SHALL have port trigger  out  1  sensor trigger pulse.
REQ-010 SHALL have port distancia_cm  out  9  last distance in cm.
REQ-011 SHALL have port pronto  out  1  one-cycle pulse on completion, success or error.
REQ-012 SHALL have port erro  out  1  last measurement timed out.
REQ-013 SHALL have port ocupado  out  1  high in every state except IDLE.

Function
REQ-014 SHALL pass echo through a 2-flop synchronizer; all echo references below use the synchronized value (echo_s).
REQ-015 SHALL implement states IDLE, TRIGGER, WAIT_ECHO, MEASURE, DONE, HOLDOFF.
REQ-016 IDLE: medir=1 SHALL move the FSM to TRIGGER on the next edge; clear erro and both counters on that edge; echo SHALL be ignored.
REQ-017 TRIGGER: trigger SHALL be 1 for exactly TRIG_CYCLES cycles, registered and glitch-free; then go to WAIT_ECHO.
REQ-018 WAIT_ECHO: a rising edge of echo_s SHALL move the FSM to MEASURE; an echo_s already high on entry SHALL NOT count as an edge.
REQ-019 WAIT_ECHO: after TIMEOUT_CYCLES without a rise SHALL set erro=1, set distancia_cm=511, and go to DONE.
REQ-020 MEASURE: SHALL run a sub-counter; each time it reaches US_PER_CM-1, SHALL wrap it to 0 and increment the cm counter (floor division, no divider).
REQ-021 The cm counter SHALL saturate at 511.
REQ-022 MEASURE: echo_s falling SHALL load distancia_cm from the cm counter and go to DONE.
REQ-023 MEASURE: echo_s high for TIMEOUT_CYCLES SHALL set erro=1, set distancia_cm=511, and go to DONE.
REQ-024 DONE: SHALL assert pronto for exactly one cycle, then go to HOLDOFF.
REQ-025 HOLDOFF: SHALL wait HOLDOFF_CYCLES, then go to IDLE; medir during HOLDOFF SHALL be ignored, not queued.
REQ-026 medir held high SHALL produce back-to-back measurements separated by HOLDOFF.
REQ-027 distancia_cm SHALL hold its value between measurements; it SHALL change only in the DONE transition.
REQ-028 Latency, echo fall to pronto: 2 synchronizer cycles + 1 cycle.

Reset
REQ-029 reset=0 SHALL force, asynchronously: state=IDLE, trigger=0, pronto=0, erro=0, ocupado=0, distancia_cm=0, all counters=0, synchronizer flops=0.
REQ-030 Reset asserted mid-measurement SHALL drop trigger immediately; no pronto SHALL be produced for the aborted measurement.

Configuration
REQ-031 Macro HCSR04_AUTO_EN defined: HOLDOFF SHALL go directly to TRIGGER, giving continuous measurement with medir ignored; the first measurement after reset still requires medir=1.
REQ-032 Macro HCSR04_AUTO_EN undefined: HOLDOFF SHALL return to IDLE per REQ-025.

Verification
REQ-033 Sensor model, distance code 00 (58 us echo), medir pulse -> trigger 12 cycles, pronto once, distancia_cm=1, erro=0.
REQ-034 Codes 01/10/11 (348/580/812 us echo) -> distancia_cm=6/10/14 respectively.
REQ-035 echo tied low -> pronto after 12+TIMEOUT_CYCLES+1 cycles, erro=1, distancia_cm=511; the next good measurement clears erro.
REQ-036 echo stuck high from before trigger -> no MEASURE entry; WAIT_ECHO timeout, erro=1.
REQ-037 reset=0 pulsed midway through a 812 us echo -> trigger=0, ocupado=0, distancia_cm=0, no pronto; the next medir measures 14.
REQ-038 HCSR04_AUTO_EN defined, one medir pulse, then code changed 00->11 -> successive pronto pulses spaced by HOLDOFF, distancia_cm moves 1->14.

Source files
------------

// File: rtl/hcsr04_controller.sv
// HC-SR04 ultrasonic ranger controller: trigger pulse, echo timing, floor conversion to centimetres.
// Optional build macro HCSR04_AUTO_EN: after the first medir request, measurements repeat continuously.
module hcsr04_controller #(
    parameter int TRIG_CYCLES    = 12,
    parameter int US_PER_CM      = 58,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int HOLDOFF_CYCLES = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       echo,
    output logic       trigger,
    output logic [8:0] distancia_cm,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado
);

    localparam int MAX_A    = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_WAIT = (MAX_A > TRIG_CYCLES) ? MAX_A : TRIG_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam int SW       = $clog2(US_PER_CM + 1);

    localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST     = SW'(US_PER_CM - 1);
    localparam logic [8:0]    CM_MAX       = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_ECHO,
        MEASURE,
        DONE,
        HOLDOFF
    } state_t;

    state_t        state_reg, state_next;
    logic          echo_meta_reg, echo_s_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] sub_reg, sub_next;
    logic [8:0]    cm_reg, cm_next;
    logic          low_seen_reg, low_seen_next;
    logic          trigger_reg, trigger_next;
    logic          pronto_reg, pronto_next;
    logic          erro_reg, erro_next;
    logic          ocupado_reg, ocupado_next;
    logic [8:0]    dist_reg, dist_next;

    assign trigger      = trigger_reg;
    assign pronto       = pronto_reg;
    assign erro         = erro_reg;
    assign ocupado      = ocupado_reg;
    assign distancia_cm = dist_reg;

    // Two-flop synchronizer for the asynchronous echo line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta_reg <= 1'b0;
            echo_s_reg    <= 1'b0;
        end else begin
            echo_meta_reg <= echo;
            echo_s_reg    <= echo_meta_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            sub_reg      <= '0;
            cm_reg       <= '0;
            low_seen_reg <= 1'b0;
            trigger_reg  <= 1'b0;
            pronto_reg   <= 1'b0;
            erro_reg     <= 1'b0;
            ocupado_reg  <= 1'b0;
            dist_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sub_reg      <= sub_next;
            cm_reg       <= cm_next;
            low_seen_reg <= low_seen_next;
            trigger_reg  <= trigger_next;
            pronto_reg   <= pronto_next;
            erro_reg     <= erro_next;
            ocupado_reg  <= ocupado_next;
            dist_reg     <= dist_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sub_next      = sub_reg;
        cm_next       = cm_reg;
        low_seen_next = low_seen_reg;
        erro_next     = erro_reg;
        dist_next     = dist_reg;

        case (state_reg)
            IDLE: begin
                if (medir) begin
                    state_next = TRIGGER;
                    cnt_next   = '0;
                    sub_next   = '0;
                    cm_next    = '0;
                    erro_next  = 1'b0;
                end
            end

            TRIGGER: begin
                if (cnt_reg == TRIG_LAST) begin
                    state_next    = WAIT_ECHO;
                    cnt_next      = '0;
                    low_seen_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // A rise only counts once echo_s has been seen low inside this state,
            // so a line already high on entry never starts a measurement.
            WAIT_ECHO: begin
                if (echo_s_reg && low_seen_reg) begin
                    state_next = MEASURE;
                    cnt_next   = CW'(1);
                    sub_next   = SW'(1);
                    cm_next    = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = DONE;
                    erro_next  = 1'b1;
                    dist_next  = CM_MAX;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (!echo_s_reg) begin
                        low_seen_next = 1'b1;
                    end
                end
            end

            // The rising cycle was already counted on entry; each further high
            // cycle advances the sub-counter, one cm per US_PER_CM high cycles.
            MEASURE: begin
                if (!echo_s_reg) begin
                    state_next = DONE;
                    dist_next  = cm_reg;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = DONE;
                    erro_next  = 1'b1;
                    dist_next  = CM_MAX;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (sub_reg == SUB_LAST) begin
                        sub_next = '0;
                        if (cm_reg != CM_MAX) begin
                            cm_next = cm_reg + 9'd1;
                        end
                    end else begin
                        sub_next = sub_reg + 1'b1;
                    end
                end
            end

            DONE: begin
                state_next = HOLDOFF;
                cnt_next   = '0;
            end

            HOLDOFF: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next = '0;
`ifdef HCSR04_AUTO_EN
                    state_next = TRIGGER;
                    sub_next   = '0;
                    cm_next    = '0;
                    erro_next  = 1'b0;
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Outputs are registered from the next state so they are glitch-free.
        trigger_next = (state_next == TRIGGER);
        pronto_next  = (state_next == DONE);
        ocupado_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_hcsr04_controller.sv
// Directed bench for hcsr04_controller: sensor model plus scoreboard of expected (erro, distance) results.
module tb_hcsr04_controller;

    localparam int TRIG     = 12;
    localparam int PER_CM   = 58;
    localparam int TMO      = 1500;
    localparam int HOLD     = 200;
    localparam int ECHO_DLY = 30;
    localparam int BUDGET   = TRIG + TMO + 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       medir;
    logic       echo;
    logic       echo_model = 1'b0;
    logic       echo_stuck;
    logic       trigger;
    logic       pronto;
    logic       erro;
    logic       ocupado;
    logic [8:0] distancia_cm;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int trig_run = 0;
    int last_trig = 0;
    int pronto_count = 0;
    int double_pronto = 0;
    logic pronto_prev = 1'b0;
    int fall_cyc = 0;
    int echo_len = PER_CM;
    logic sensor_en = 1'b0;
    logic [9:0] sb_q[$];

    hcsr04_controller #(
        .TRIG_CYCLES   (TRIG),
        .US_PER_CM     (PER_CM),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .medir       (medir),
        .echo        (echo),
        .trigger     (trigger),
        .distancia_cm(distancia_cm),
        .pronto      (pronto),
        .erro        (erro),
        .ocupado     (ocupado)
    );

    assign echo = echo_model | echo_stuck;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Sensor: after each trigger pulse, wait, then echo high for echo_len cycles.
    always begin
        @(negedge trigger);
        if (sensor_en) begin
            repeat (ECHO_DLY) @(negedge clock);
            echo_model = 1'b1;
            repeat (echo_len) @(negedge clock);
            echo_model = 1'b0;
            fall_cyc = cyc;
        end
    end

    always @(negedge clock) begin
        if (trigger === 1'b1) begin
            trig_run <= trig_run + 1;
        end else if (trig_run != 0) begin
            last_trig <= trig_run;
            trig_run  <= 0;
        end
        if (pronto === 1'b1) begin
            pronto_count <= pronto_count + 1;
            if (pronto_prev) double_pronto <= double_pronto + 1;
        end
        pronto_prev <= (pronto === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_medir();
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    // Waits (bounded) for pronto, pops the scoreboard and compares the result.
    task automatic wait_pronto(input string tag, input int budget, output int lat, output int pcyc);
        int n;
        logic [9:0] exp;
        n = 0;
        while (pronto !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        lat  = n;
        pcyc = cyc;
        check({tag, "_pronto"}, {31'd0, pronto}, 32'd1);
        if (pronto === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, "_dist"}, {23'd0, distancia_cm}, {23'd0, exp[8:0]});
            check({tag, "_erro"}, {31'd0, erro}, {31'd0, exp[9]});
        end
        @(negedge clock);
        check({tag, "_pronto_width"}, {31'd0, pronto}, 32'd0);
    endtask

    task automatic measure(input string tag, input int len, input logic [8:0] d);
        int lat;
        int pc;
        echo_len  = len;
        sensor_en = 1'b1;
        sb_q.push_back({1'b0, d});
        pulse_medir();
        wait_pronto(tag, BUDGET, lat, pc);
        check({tag, "_trig_width"}, last_trig, TRIG);
        check({tag, "_fall_to_pronto"}, pc - fall_cyc, 3);
        repeat (HOLD + 5) @(negedge clock);
        check({tag, "_idle"}, {31'd0, ocupado}, 32'd0);
    endtask

    initial begin
        int lat, pc, pc1, n, pcount;
        reset = 1'b0;
        medir = 1'b0;
        echo_stuck = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_trigger", {31'd0, trigger}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_erro", {31'd0, erro}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_dist", {23'd0, distancia_cm}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

`ifdef HCSR04_AUTO_EN
        echo_len  = PER_CM;
        sensor_en = 1'b1;
        sb_q.push_back({1'b0, 9'd1});
        pulse_medir();
        wait_pronto("auto1", BUDGET, lat, pc1);
        echo_len = 812;
        sb_q.push_back({1'b0, 9'd14});
        n = 0;
        while (trigger !== 1'b1 && n < HOLD + 50) begin
            @(negedge clock);
            n++;
        end
        check("auto_restart_gap", cyc - pc1, HOLD + 1);
        wait_pronto("auto2", BUDGET, lat, pc);
        sb_q.push_back({1'b0, 9'd14});
        wait_pronto("auto3", BUDGET + HOLD, lat, pc);
        check("auto_double_pronto", double_pronto, 0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
`else
        measure("d1", 58, 9'd1);
        measure("d6", 348, 9'd6);
        measure("d10", 580, 9'd10);
        measure("d14", 812, 9'd14);
        measure("floor", 115, 9'd1);

        // Echo tied low: WAIT_ECHO timeout.
        sensor_en = 1'b0;
        sb_q.push_back({1'b1, 9'd511});
        pulse_medir();
        wait_pronto("tmo_low", BUDGET, lat, pc);
        check("tmo_low_latency", lat + 1, TRIG + TMO + 1);
        repeat (HOLD + 5) @(negedge clock);

        // Next good measurement clears erro on the start edge.
        echo_len  = PER_CM;
        sensor_en = 1'b1;
        sb_q.push_back({1'b0, 9'd1});
        pulse_medir();
        check("erro_cleared", {31'd0, erro}, 32'd0);
        wait_pronto("after_tmo", BUDGET, lat, pc);
        repeat (HOLD + 5) @(negedge clock);

        // Echo high from before trigger, released while waiting: must still time out.
        sensor_en  = 1'b0;
        echo_stuck = 1'b1;
        repeat (5) @(negedge clock);
        sb_q.push_back({1'b1, 9'd511});
        pulse_medir();
        repeat (300) @(negedge clock);
        echo_stuck = 1'b0;
        wait_pronto("stuck_high", BUDGET, lat, pc);
        check("stuck_latency", lat + 301, TRIG + TMO + 1);
        repeat (HOLD + 5) @(negedge clock);

        // medir during HOLDOFF is dropped.
        echo_len  = 348;
        sensor_en = 1'b1;
        sb_q.push_back({1'b0, 9'd6});
        pulse_medir();
        wait_pronto("holdoff", BUDGET, lat, pc);
        repeat (20) @(negedge clock);
        pcount = pronto_count;
        pulse_medir();
        repeat (HOLD + 20) @(negedge clock);
        check("holdoff_ignored_busy", {31'd0, ocupado}, 32'd0);
        check("holdoff_ignored_count", pronto_count, pcount);

        // medir held high: back-to-back measurements separated by HOLDOFF.
        sb_q.push_back({1'b0, 9'd6});
        sb_q.push_back({1'b0, 9'd6});
        medir = 1'b1;
        wait_pronto("held1", BUDGET, lat, pc1);
        n = 0;
        while (trigger !== 1'b1 && n < HOLD + 50) begin
            @(negedge clock);
            n++;
        end
        check("held_gap", cyc - pc1, HOLD + 2);
        medir = 1'b0;
        wait_pronto("held2", BUDGET, lat, pc);
        repeat (HOLD + 5) @(negedge clock);
        check("held_idle", {31'd0, ocupado}, 32'd0);

        // Reset during the trigger pulse drops trigger at once.
        sensor_en = 1'b0;
        pulse_medir();
        repeat (4) @(negedge clock);
        check("rst_trig_before", {31'd0, trigger}, 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_trig_drop", {31'd0, trigger}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // Reset midway through an 812-cycle echo.
        measure("pre_rst", 348, 9'd6);
        pcount = pronto_count;
        echo_len  = 812;
        sensor_en = 1'b1;
        pulse_medir();
        repeat (TRIG + ECHO_DLY + 400) @(negedge clock);
        check("rst_mid_busy", {31'd0, ocupado}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_trigger", {31'd0, trigger}, 32'd0);
        check("rst_mid_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_mid_dist", {23'd0, distancia_cm}, 32'd0);
        check("rst_mid_pronto", {31'd0, pronto}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        while (echo_model !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        check("rst_mid_no_pronto", pronto_count, pcount);
        measure("after_rst", 812, 9'd14);
        check("double_pronto", double_pronto, 0);
`endif

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
